// File: rtl/image_drain_if.sv
// Read-port and output-stream bundle for image_drain.
// The str_img_last signal exists only when IMAGE_DRAIN_LAST_EN is defined.
interface image_drain_if #(
  parameter int DW = 256,
  parameter int AW = 16
);
  logic          rd_val;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] str_img_bus;
  logic          str_img_val;
  logic          str_img_rdy;
`ifdef IMAGE_DRAIN_LAST_EN
  logic          str_img_last;
`endif

  modport master (
    output rd_val, rd_addr, str_img_bus, str_img_val,
`ifdef IMAGE_DRAIN_LAST_EN
    output str_img_last,
`endif
    input  rd_data, str_img_rdy
  );

  modport slave (
    input  rd_val, rd_addr, str_img_bus, str_img_val,
`ifdef IMAGE_DRAIN_LAST_EN
    input  str_img_last,
`endif
    output rd_data, str_img_rdy
  );
endinterface

// File: rtl/image_drain.sv
// Gather-reads image_mem over depth/row/pixel counters and streams words out through a credit-managed FIFO.
// Optional macro IMAGE_DRAIN_LAST_EN adds str_img_last, flagging the final word of a pass.
module image_drain #(
  parameter int CFG_DWIDTH  = 32,
  parameter int CFG_AWIDTH  = 5,
  parameter int DEPTH_NB    = 16,
  parameter int IMG_WIDTH   = 16,
  parameter int MEM_AWIDTH  = 16,
  parameter int MEM_RD_LAT  = 2,
  parameter int FIFO_AWIDTH = 3,
  parameter logic [CFG_AWIDTH-1:0] CFG_IR_IMG_W = CFG_AWIDTH'(0),
  parameter logic [CFG_AWIDTH-1:0] CFG_IR_START = CFG_AWIDTH'(1),
  parameter logic [CFG_AWIDTH-1:0] CFG_IR_STEP  = CFG_AWIDTH'(2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CFG_DWIDTH-1:0] cfg_data,
  input  logic [CFG_AWIDTH-1:0] cfg_addr,
  input  logic                  cfg_valid,
  input  logic                  next,
  output logic                  busy,
  image_drain_if.master         drain
);
  localparam int DW = IMG_WIDTH * DEPTH_NB;
`ifdef IMAGE_DRAIN_LAST_EN
  localparam int FW = DW + 1;
`else
  localparam int FW = DW;
`endif
  localparam logic [FIFO_AWIDTH:0] FIFO_FULL = {1'b1, {FIFO_AWIDTH{1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nxt;

  logic [31:0] img_w;
  logic [15:0] img_h, start, step_p, step_r;

  logic [31:0] w_max, sp, rs, w_cnt, plane, row, pix;
  logic [15:0] h_max, d_max, h_cnt, d_cnt;
  logic [31:0] sp_new, rs_new;

  logic                  rd_val_q;
  logic [MEM_AWIDTH-1:0] rd_addr_q;
  logic [FIFO_AWIDTH:0]  credits, credits_nxt;
  logic [MEM_RD_LAT-1:0] vpipe;
  logic                  issue, pop, push, last_word;

  logic [FW-1:0]          fifo_mem [2**FIFO_AWIDTH];
  logic [FIFO_AWIDTH-1:0] wptr, rptr;
  logic [FIFO_AWIDTH:0]   count;
  logic [FW-1:0]          head, push_word;
`ifdef IMAGE_DRAIN_LAST_EN
  logic                  rd_last_q;
  logic [MEM_RD_LAT-1:0] lpipe;
`endif

  // Shadow config: a write during a pass only takes effect at the next latch.
  always_ff @(posedge clk) begin
    if (cfg_valid) begin
      if (cfg_addr == CFG_IR_IMG_W) img_w <= cfg_data[31:0];
      if (cfg_addr == CFG_IR_START) begin
        start <= cfg_data[31:16];
        img_h <= cfg_data[15:0];
      end
      if (cfg_addr == CFG_IR_STEP) begin
        step_p <= cfg_data[31:16];
        step_r <= cfg_data[15:0];
      end
    end
  end

  assign sp_new    = {16'd0, step_p} + 32'd1;
  assign rs_new    = sp_new * ({16'd0, step_r} + 32'd1);
  assign last_word = (w_cnt == w_max) && (h_cnt == h_max) && (d_cnt == d_max);
  assign pop       = drain.str_img_val && drain.str_img_rdy;
  assign push      = vpipe[MEM_RD_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    issue       = 1'b0;
    issue       = (state == RUN) && (credits < FIFO_FULL);
    credits_nxt = credits + {{FIFO_AWIDTH{1'b0}}, issue} - {{FIFO_AWIDTH{1'b0}}, pop};
    case (state)
      IDLE:    if (next) state_nxt = RUN;
      RUN:     if (issue && last_word) state_nxt = DRAIN;
      DRAIN:   if (credits_nxt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Addresses advance incrementally: pixel step, then row wrap, then depth wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_val_q  <= 1'b0;
      rd_addr_q <= '0;
      credits   <= '0;
      vpipe     <= '0;
      w_max     <= '0;
      h_max     <= '0;
      d_max     <= '0;
      sp        <= '0;
      rs        <= '0;
      w_cnt     <= '0;
      h_cnt     <= '0;
      d_cnt     <= '0;
      plane     <= '0;
      row       <= '0;
      pix       <= '0;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
`ifdef IMAGE_DRAIN_LAST_EN
      rd_last_q <= 1'b0;
      lpipe     <= '0;
`endif
    end else begin
      rd_val_q <= issue;
      credits  <= credits_nxt;
      if (issue) rd_addr_q <= pix[MEM_AWIDTH-1:0];
      if (state == IDLE && next) begin
        w_max <= img_w;
        h_max <= img_h;
        d_max <= step_p;
        sp    <= sp_new;
        rs    <= rs_new;
        w_cnt <= '0;
        h_cnt <= '0;
        d_cnt <= '0;
        plane <= {16'd0, start};
        row   <= {16'd0, start};
        pix   <= {16'd0, start};
      end else if (issue) begin
        if (w_cnt != w_max) begin
          w_cnt <= w_cnt + 32'd1;
          pix   <= pix + sp;
        end else begin
          w_cnt <= '0;
          if (h_cnt != h_max) begin
            h_cnt <= h_cnt + 16'd1;
            row   <= row + rs;
            pix   <= row + rs;
          end else begin
            h_cnt <= '0;
            d_cnt <= d_cnt + 16'd1;
            plane <= plane + 32'd1;
            row   <= plane + 32'd1;
            pix   <= plane + 32'd1;
          end
        end
      end
      vpipe[0] <= rd_val_q;
      for (int i = 1; i < MEM_RD_LAT; i++) vpipe[i] <= vpipe[i-1];
`ifdef IMAGE_DRAIN_LAST_EN
      rd_last_q <= issue && last_word;
      lpipe[0]  <= rd_last_q;
      for (int i = 1; i < MEM_RD_LAT; i++) lpipe[i] <= lpipe[i-1];
`endif
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + {{FIFO_AWIDTH{1'b0}}, push} - {{FIFO_AWIDTH{1'b0}}, pop};
    end
  end

`ifdef IMAGE_DRAIN_LAST_EN
  assign push_word = {lpipe[MEM_RD_LAT-1], drain.rd_data};
`else
  assign push_word = drain.rd_data;
`endif

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= push_word;
  end

  assign head              = fifo_mem[rptr];
  assign drain.rd_val      = rd_val_q;
  assign drain.rd_addr     = rd_addr_q;
  assign drain.str_img_val = (count != '0);
  assign drain.str_img_bus = drain.str_img_val ? head[DW-1:0] : '0;
`ifdef IMAGE_DRAIN_LAST_EN
  assign drain.str_img_last = drain.str_img_val && head[DW];
`endif
endmodule

// File: tb/tb_image_drain.sv
// Self-checking bench for image_drain: vector table of passes, scoreboard of addresses/data, corner sequences.
module tb_image_drain;
  localparam int DW = 256, AW = 16, LAT = 2, FA = 3, FDEPTH = 8;

  logic clk = 1'b0;
  logic rst, cfg_valid, next, busy;
  logic [31:0] cfg_data;
  logic [4:0]  cfg_addr;

  always #5 clk = ~clk;

  image_drain_if #(.DW(DW), .AW(AW)) dif ();

  image_drain #(.MEM_RD_LAT(LAT), .FIFO_AWIDTH(FA)) dut (
    .clk(clk), .rst(rst), .cfg_data(cfg_data), .cfg_addr(cfg_addr),
    .cfg_valid(cfg_valid), .next(next), .busy(busy), .drain(dif)
  );

  typedef struct {
    int unsigned w, h, start, sp, sr;
    int pct;
    int exp_words;
  } vec_t;

  int n_tests = 0, n_fail = 0;
  int issued = 0, popped = 0, max_out = 0;
  logic [AW-1:0] exp_addr [$];
  logic [DW-1:0] exp_data [$];
  logic          exp_last [$];

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    for (int i = 0; i < 16; i++) r[i*16 +: 16] = a ^ (16'h1111 * 16'(i));
    return r;
  endfunction

  // memory model: data for the address seen LAT cycles earlier
  logic [AW-1:0] ma [LAT];
  always @(posedge clk) begin
    ma[0] <= dif.rd_addr;
    for (int i = 1; i < LAT; i++) ma[i] <= ma[i-1];
  end
  assign dif.rd_data = word_of(ma[LAT-1]);

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got unexpected event expected none", name);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (dif.rd_val) begin
        issued++;
        if (exp_addr.size() == 0) flag("rd_addr_extra");
        else chk("rd_addr", DW'(dif.rd_addr), DW'(exp_addr.pop_front()));
      end
      if (issued - popped > max_out) max_out = issued - popped;
      if (dif.str_img_val && dif.str_img_rdy) begin
        popped++;
        if (exp_data.size() == 0) flag("str_word_extra");
        else begin
          chk("str_img_bus", dif.str_img_bus, exp_data.pop_front());
`ifdef IMAGE_DRAIN_LAST_EN
          chk_int("str_img_last", int'(dif.str_img_last), int'(exp_last.pop_front()));
`else
          void'(exp_last.pop_front());
`endif
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
    cfg_addr  = a;
    cfg_data  = d;
    cfg_valid = 1'b1;
    tick(1);
    cfg_valid = 1'b0;
  endtask

  // reference addresses by direct formula, in w/h/d order
  task automatic push_model(input vec_t v);
    int unsigned a;
    int total, k;
    total = (v.w + 1) * (v.h + 1) * (v.sp + 1);
    k = 0;
    for (int unsigned d = 0; d <= v.sp; d++)
      for (int unsigned h = 0; h <= v.h; h++)
        for (int unsigned w = 0; w <= v.w; w++) begin
          a = v.start + d + w * (v.sp + 1) + h * (v.sp + 1) * (v.sr + 1);
          exp_addr.push_back(a[AW-1:0]);
          exp_data.push_back(word_of(a[AW-1:0]));
          k++;
          exp_last.push_back(k == total);
        end
  endtask

  task automatic start_pass(input vec_t v);
    issued = 0; popped = 0; max_out = 0;
    cfg_write(5'd0, v.w);
    cfg_write(5'd1, {v.start[15:0], v.h[15:0]});
    cfg_write(5'd2, {v.sp[15:0], v.sr[15:0]});
    push_model(v);
    next = 1'b1;
    tick(1);
    next = 1'b0;
  endtask

  task automatic wait_idle(input int pct, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      dif.str_img_rdy = ($urandom_range(99) < pct);
      tick(1);
      n++;
    end
    dif.str_img_rdy = 1'b1;
    if (busy) flag("busy_timeout");
    tick(1);
  endtask

  task automatic end_checks(input string tag, input int words);
    chk_int({tag, "_words"}, popped, words);
    chk_int({tag, "_addr_left"}, exp_addr.size(), 0);
    chk_int({tag, "_credits_le_depth"}, int'(max_out <= FDEPTH), 1);
  endtask

  vec_t vt [6];
  vec_t v;

  initial begin
    int first_val, last_val, val_cnt;
    logic busy11, busy12;
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int first_val, last_val, val_cnt;
    logic busy11, busy12;
    vt[0] = '{w:3, h:1, start:'h10,   sp:0, sr:3, pct:100, exp_words:8};
    vt[1] = '{w:1, h:0, start:0,      sp:1, sr:1, pct:100, exp_words:4};
    vt[2] = '{w:4, h:2, start:'h100,  sp:2, sr:5, pct:50,  exp_words:45};
    vt[3] = '{w:7, h:3, start:'hfff0, sp:0, sr:7, pct:50,  exp_words:32};
    vt[4] = '{w:0, h:0, start:'h20,   sp:0, sr:0, pct:30,  exp_words:1};
    vt[5] = '{w:2, h:1, start:'h40,   sp:3, sr:2, pct:70,  exp_words:24};

    rst = 1'b1; next = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
    dif.str_img_rdy = 1'b1;
    tick(3);
    chk("reset_ctrl", DW'({busy, dif.rd_val, dif.str_img_val, dif.rd_addr}), '0);
    chk("reset_bus", dif.str_img_bus, '0);
    rst = 1'b0;
    tick(2);
    chk("idle_ctrl", DW'({busy, dif.rd_val, dif.str_img_val}), '0);

    // scenario 1 with cycle-exact latency, gap and busy-drop checks
    start_pass(vt[0]);
    first_val = -1; last_val = -1; val_cnt = 0; busy11 = 1'b0; busy12 = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick(1);
      if (dif.str_img_val) begin
        if (first_val < 0) first_val = c;
        last_val = c;
        val_cnt++;
      end
      if (c == LAT + 9)  busy11 = busy;
      if (c == LAT + 10) busy12 = busy;
    end
    chk_int("first_val_latency", first_val, LAT + 2);
    chk_int("val_no_gap", last_val - first_val + 1, val_cnt);
    chk_int("busy_before_last_pop", int'(busy11), 1);
    chk_int("busy_after_last_pop", int'(busy12), 0);
    end_checks("scn1", 8);

    for (int i = 0; i < 6; i++) begin
      v = vt[i];
      start_pass(v);
      wait_idle(v.pct, 2000);
      end_checks($sformatf("vec%0d", i), v.exp_words);
    end

    // backpressure: stall long enough to fill every credit
    v = '{w:15, h:1, start:'h200, sp:0, sr:15, pct:100, exp_words:32};
    start_pass(v);
    tick(6);
    dif.str_img_rdy = 1'b0;
    tick(20);
    chk_int("stall_outstanding", issued - popped, FDEPTH);
    chk_int("stall_rd_val", int'(dif.rd_val), 0);
    chk_int("stall_val_held", int'(dif.str_img_val), 1);
    wait_idle(100, 2000);
    end_checks("stall", 32);

    // next during RUN must be ignored
    v = '{w:15, h:0, start:'h300, sp:0, sr:0, pct:100, exp_words:16};
    start_pass(v);
    tick(3);
    next = 1'b1;
    tick(1);
    next = 1'b0;
    wait_idle(100, 2000);
    end_checks("next_in_run", 16);
    tick(5);
    chk_int("no_second_pass", int'(busy), 0);

    // reset mid-pass
    v = '{w:15, h:1, start:'h400, sp:0, sr:15, pct:100, exp_words:32};
    start_pass(v);
    tick(8);
    rst = 1'b1;
    #1;
    chk("midrst_ctrl", DW'({busy, dif.rd_val, dif.str_img_val, dif.rd_addr}), '0);
    chk("midrst_bus", dif.str_img_bus, '0);
    exp_addr.delete(); exp_data.delete(); exp_last.delete();
    tick(2);
    rst = 1'b0;
    tick(2);
    start_pass(vt[0]);
    wait_idle(100, 2000);
    end_checks("after_rst", 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
